bin_morph_3x3: RTL

- Binary 3x3 morphology stage that cleans the 1-bit foreground mask before the bounding-box/rectangle stage in the human-detector chain.
- Consumes the binarised pixel stream and sync signals, and emits a filtered 1-bit stream with delayed sync signals.
- Selectable per frame: bypass, erode, dilate or majority filter. This removes isolated noise pixels that would otherwise inflate the detected box.

---
 rtl/det_pkg.sv | 25 ++
 rtl/bin_line_buf.sv | 30 +++
 rtl/bin_morph_3x3.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/det_pkg.sv
// Shared definitions for the detector mask-cleaning stages: morphology modes,
// default geometry and a popcount helper.
package det_pkg;

    typedef enum logic [1:0] {
        MORPH_BYPASS = 2'b00,
        MORPH_ERODE  = 2'b01,
        MORPH_DILATE = 2'b10,
        MORPH_MAJ    = 2'b11
    } morph_mode_e;

    localparam logic [3:0] MAJ_THRESH    = 4'd5;
    localparam int         DEF_IMG_WIDTH = 1280;
    localparam int         DEF_CNT_W     = 12;

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < 9; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

endpackage

// File: rtl/bin_line_buf.sv
// Single-port 1-bit line buffer: asynchronous read of the old word, write of
// the new word on the same enabled clock edge (read-before-write).
module bin_line_buf #(
    parameter int DEPTH = 1280,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic          wr_data,
    output logic          rd_data
);

    localparam int            IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LIMIT = AW'(DEPTH);

    logic mem_r [DEPTH];
    logic in_range_s;

    assign in_range_s = (addr < LIMIT);
    assign rd_data    = in_range_s ? mem_r[addr[IW-1:0]] : 1'b0;

    // Line storage; contents need no reset because the border rule masks them.
    always_ff @(posedge clk) begin
        if (en && in_range_s) begin
            mem_r[addr[IW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/bin_morph_3x3.sv
// Binary 3x3 morphology (bypass/erode/dilate/majority) on the foreground mask
// stream, fixed 2-clock latency with matching sync delay.
module bin_morph_3x3
    import det_pkg::*;
#(
    parameter int IMG_WIDTH = DEF_IMG_WIDTH,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic       per_img_Bit,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic       post_img_Bit
);

    localparam logic [CNT_W-1:0] X_LIM  = CNT_W'(IMG_WIDTH);
    localparam logic [CNT_W-1:0] Y_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] BORDER = CNT_W'(2);

    logic             vsync_prev_r;
    logic             href_prev_r;
    logic [CNT_W-1:0] x_cnt_r;
    logic [CNT_W-1:0] y_cnt_r;
    morph_mode_e      mode_r;
    logic [1:0]       win0_r, win1_r, win2_r;
    logic [1:0]       vs_d_r, hr_d_r, ce_d_r;
    logic             and_r, or_r, ctr_r, ok_r;
    logic [3:0]       pop_r;
    logic             bit_out_r;

    logic             pix_valid_s;
    logic             href_fall_s;
    logic             vsync_rise_s;
    logic             in_line_s;
    logic             buf_en_s;
    logic             rd0_s, rd1_s;
    logic [8:0]       win_s;
    logic             ok_s;
    logic             sel_s;

    assign pix_valid_s  = per_frame_clken & per_frame_href;
    assign href_fall_s  = href_prev_r & ~per_frame_href;
    assign vsync_rise_s = per_frame_vsync & ~vsync_prev_r;
    assign in_line_s    = (x_cnt_r < X_LIM);
    assign buf_en_s     = pix_valid_s & in_line_s;

    // Window rows y-2, y-1, y; within a row: column x-2, x-1, then the live column x.
    assign win_s = {win0_r, rd0_s, win1_r, rd1_s, win2_r, per_img_Bit};
    assign ok_s  = pix_valid_s & in_line_s & (x_cnt_r >= BORDER) & (y_cnt_r >= BORDER);

    bin_line_buf #(.DEPTH(IMG_WIDTH), .AW(CNT_W)) u_buf1 (
        .clk     (clk),
        .en      (buf_en_s),
        .addr    (x_cnt_r),
        .wr_data (per_img_Bit),
        .rd_data (rd1_s)
    );

    bin_line_buf #(.DEPTH(IMG_WIDTH), .AW(CNT_W)) u_buf0 (
        .clk     (clk),
        .en      (buf_en_s),
        .addr    (x_cnt_r),
        .wr_data (rd1_s),
        .rd_data (rd0_s)
    );

    // Edge detectors, column/row counters and per-frame mode latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev_r <= 1'b0;
            href_prev_r  <= 1'b0;
            x_cnt_r      <= '0;
            y_cnt_r      <= '0;
            mode_r       <= MORPH_BYPASS;
        end else begin
            vsync_prev_r <= per_frame_vsync;
            href_prev_r  <= per_frame_href;
            if (href_fall_s) begin
                x_cnt_r <= '0;
            end else if (pix_valid_s && (x_cnt_r != X_LIM)) begin
                x_cnt_r <= x_cnt_r + CNT_W'(1);
            end
            // vsync has priority so a line overlapping the blank cannot advance the row
            if (per_frame_vsync) begin
                y_cnt_r <= '0;
            end else if (href_fall_s && (y_cnt_r != Y_MAX)) begin
                y_cnt_r <= y_cnt_r + CNT_W'(1);
            end
            if (vsync_rise_s) begin
                mode_r <= morph_mode_e'(mode);
            end
        end
    end

    // Column history of the three window rows, advanced only on valid pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win0_r <= 2'b00;
            win1_r <= 2'b00;
            win2_r <= 2'b00;
        end else if (pix_valid_s) begin
            win0_r <= {win0_r[0], rd0_s};
            win1_r <= {win1_r[0], rd1_s};
            win2_r <= {win2_r[0], per_img_Bit};
        end
    end

    // Stage 1: reductions over the window including the live column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            and_r <= 1'b0;
            or_r  <= 1'b0;
            ctr_r <= 1'b0;
            ok_r  <= 1'b0;
            pop_r <= 4'd0;
        end else begin
            and_r <= &win_s;
            or_r  <= |win_s;
            ctr_r <= win1_r[0];
            ok_r  <= ok_s;
            pop_r <= popcount9(win_s);
        end
    end

    // Mode-dependent result selection.
    always_comb begin
        sel_s = 1'b0;
        case (mode_r)
            MORPH_BYPASS: sel_s = ctr_r;
            MORPH_ERODE:  sel_s = and_r;
            MORPH_DILATE: sel_s = or_r;
            MORPH_MAJ:    sel_s = (pop_r >= MAJ_THRESH);
            default:      sel_s = 1'b0;
        endcase
    end

    // Stage 2 pixel register and the ungated 2-deep sync delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_out_r <= 1'b0;
            vs_d_r    <= 2'b00;
            hr_d_r    <= 2'b00;
            ce_d_r    <= 2'b00;
        end else begin
            bit_out_r <= ok_r & sel_s;
            vs_d_r    <= {vs_d_r[0], per_frame_vsync};
            hr_d_r    <= {hr_d_r[0], per_frame_href};
            ce_d_r    <= {ce_d_r[0], per_frame_clken};
        end
    end

    assign post_frame_vsync = vs_d_r[1];
    assign post_frame_href  = hr_d_r[1];
    assign post_frame_clken = ce_d_r[1];
    assign post_img_Bit     = bit_out_r;

endmodule
